// File: rtl/add_cp.sv
// add_cp: transmit-side cyclic-prefix insertion for the OFDM chain.
// Ping-pong symbol store; each symbol leaves as its last LCP samples, then all NFFT.
module add_cp #(
   parameter int NFFT = 48,
   parameter int LCP  = 16,
   parameter int DW   = 16
) (
   input  logic          CLK_II,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I_r,
   input  logic [DW-1:0] DAT_I_i,
   input  logic          DIN_VLD,
   output logic          DIN_RDY,
   output logic [DW-1:0] DAT_O_r,
   output logic [DW-1:0] DAT_O_i,
   output logic          DOUT_VLD,
   input  logic          DOUT_RDY,
   output logic          SOF_O,
   output logic          EOF_O
);

   localparam int NSYM = NFFT + LCP;
   localparam int AW   = $clog2(NFFT);
   localparam int CW   = $clog2(NSYM);

   localparam logic [AW-1:0] A_LAST = AW'(NFFT - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NSYM - 1);
   localparam logic [CW-1:0] C_LCP  = CW'(LCP);
   localparam logic [CW-1:0] C_OFS  = CW'(NFFT - LCP);

   logic [2*DW-1:0] r_mem0 [NFFT];
   logic [2*DW-1:0] r_mem1 [NFFT];

   logic [1:0]      r_full;
   logic            r_wr_bank;
   logic [AW-1:0]   r_wr_addr;
   logic            r_rd_bank;
   logic [CW-1:0]   r_rd_cnt;
   logic            r_dout_vld;
   logic [DW-1:0]   r_dat_r;
   logic [DW-1:0]   r_dat_i;
   logic            r_sof;
   logic            r_eof;

   logic            w_wr_en;
   logic            w_wr_last;
   logic            w_load;
   logic            w_rd_last;
   logic [AW-1:0]   w_rd_addr;
   logic [2*DW-1:0] w_rd_word;
   logic [1:0]      w_full_nxt;

   // Writer only sees a bank once the reader has released it.
   assign DIN_RDY   = ~RST_I & ~r_full[r_wr_bank];
   assign w_wr_en   = DIN_VLD & DIN_RDY;
   assign w_wr_last = (r_wr_addr == A_LAST);

   assign w_load    = r_full[r_rd_bank] & (~r_dout_vld | DOUT_RDY);
   assign w_rd_last = (r_rd_cnt == C_LAST);

   // Prefix phase reads the symbol tail; data phase reads from index 0.
   always_comb begin
      w_rd_addr = '0;
      if (r_rd_cnt < C_LCP) begin
         w_rd_addr = AW'(C_OFS + r_rd_cnt);
      end else begin
         w_rd_addr = AW'(r_rd_cnt - C_LCP);
      end
   end

   assign w_rd_word = r_rd_bank ? r_mem1[w_rd_addr] : r_mem0[w_rd_addr];

   always_ff @(posedge CLK_II) begin
      if (w_wr_en && !r_wr_bank) begin
         r_mem0[r_wr_addr] <= {DAT_I_r, DAT_I_i};
      end
      if (w_wr_en && r_wr_bank) begin
         r_mem1[r_wr_addr] <= {DAT_I_r, DAT_I_i};
      end
   end

   always_ff @(posedge CLK_II or posedge RST_I) begin
      if (RST_I) begin
         r_wr_addr <= '0;
         r_wr_bank <= 1'b0;
      end else if (w_wr_en) begin
         if (w_wr_last) begin
            r_wr_addr <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_addr <= r_wr_addr + AW'(1);
         end
      end
   end

   // Set and clear never target the same bank in one cycle.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_en && w_wr_last) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_load && w_rd_last) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge CLK_II or posedge RST_I) begin
      if (RST_I) begin
         r_full <= '0;
      end else begin
         r_full <= w_full_nxt;
      end
   end

   always_ff @(posedge CLK_II or posedge RST_I) begin
      if (RST_I) begin
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
      end else if (w_load) begin
         if (w_rd_last) begin
            r_rd_cnt  <= '0;
            r_rd_bank <= ~r_rd_bank;
         end else begin
            r_rd_cnt  <= r_rd_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK_II or posedge RST_I) begin
      if (RST_I) begin
         r_dout_vld <= 1'b0;
         r_dat_r    <= '0;
         r_dat_i    <= '0;
         r_sof      <= 1'b0;
         r_eof      <= 1'b0;
      end else if (w_load) begin
         r_dout_vld <= 1'b1;
         r_dat_r    <= w_rd_word[2*DW-1:DW];
         r_dat_i    <= w_rd_word[DW-1:0];
         r_sof      <= (r_rd_cnt == '0);
         r_eof      <= w_rd_last;
      end else if (DOUT_RDY) begin
         r_dout_vld <= 1'b0;
      end
   end

   assign DAT_O_r  = r_dat_r;
   assign DAT_O_i  = r_dat_i;
   assign DOUT_VLD = r_dout_vld;
   assign SOF_O    = r_sof;
   assign EOF_O    = r_eof;

endmodule

// File: tb/tb_add_cp.sv
// tb_add_cp: directed bench for add_cp.
// Three instances cover the default shape, LCP=0 and LCP=NFFT.
`timescale 1ns/1ps
module tb_add_cp;

   typedef struct packed {
      logic [15:0] r;
      logic [15:0] i;
      logic        sof;
      logic        eof;
   } smp_t;

   int NF [3] = '{48, 8, 16};
   int LC [3] = '{16, 0, 16};

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [15:0] din_r  [3];
   logic [15:0] din_i  [3];
   logic [15:0] dout_r [3];
   logic [15:0] dout_i [3];
   logic din_vld  [3];
   logic din_rdy  [3];
   logic dout_vld [3];
   logic dout_rdy [3];
   logic sof      [3];
   logic eof      [3];

   logic [31:0] src  [$];
   logic [31:0] sym  [$];
   smp_t        expq [$];
   smp_t        obs  [$];

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;

   always #5 clk = ~clk;

   add_cp #(.NFFT(48), .LCP(16), .DW(16)) u_dut0 (
      .CLK_II(clk), .RST_I(rst),
      .DAT_I_r(din_r[0]), .DAT_I_i(din_i[0]),
      .DIN_VLD(din_vld[0]), .DIN_RDY(din_rdy[0]),
      .DAT_O_r(dout_r[0]), .DAT_O_i(dout_i[0]),
      .DOUT_VLD(dout_vld[0]), .DOUT_RDY(dout_rdy[0]),
      .SOF_O(sof[0]), .EOF_O(eof[0])
   );

   add_cp #(.NFFT(8), .LCP(0), .DW(16)) u_dut1 (
      .CLK_II(clk), .RST_I(rst),
      .DAT_I_r(din_r[1]), .DAT_I_i(din_i[1]),
      .DIN_VLD(din_vld[1]), .DIN_RDY(din_rdy[1]),
      .DAT_O_r(dout_r[1]), .DAT_O_i(dout_i[1]),
      .DOUT_VLD(dout_vld[1]), .DOUT_RDY(dout_rdy[1]),
      .SOF_O(sof[1]), .EOF_O(eof[1])
   );

   add_cp #(.NFFT(16), .LCP(16), .DW(16)) u_dut2 (
      .CLK_II(clk), .RST_I(rst),
      .DAT_I_r(din_r[2]), .DAT_I_i(din_i[2]),
      .DIN_VLD(din_vld[2]), .DIN_RDY(din_rdy[2]),
      .DAT_O_r(dout_r[2]), .DAT_O_i(dout_i[2]),
      .DOUT_VLD(dout_vld[2]), .DOUT_RDY(dout_rdy[2]),
      .SOF_O(sof[2]), .EOF_O(eof[2])
   );

   // One clock of traffic on instance d; builds the golden CP stream as symbols complete.
   task automatic step(input int d, input bit ven, input bit rdy, output bit acc);
      logic [31:0] w;
      smp_t s;
      dout_rdy[d] = rdy;
      if (ven && src.size() > 0) begin
         din_vld[d] = 1'b1;
         din_r[d]   = src[0][31:16];
         din_i[d]   = src[0][15:0];
      end else begin
         din_vld[d] = 1'b0;
      end
      acc = din_vld[d] && din_rdy[d];
      if (dout_vld[d] && rdy) begin
         s.r = dout_r[d]; s.i = dout_i[d]; s.sof = sof[d]; s.eof = eof[d];
         obs.push_back(s);
      end
      if (acc) begin
         w = src.pop_front();
         sym.push_back(w);
         n_acc++;
         if (sym.size() == NF[d]) begin
            for (int j = 0; j < NF[d] + LC[d]; j++) begin
               int idx;
               smp_t e;
               idx   = (j < LC[d]) ? NF[d] - LC[d] + j : j - LC[d];
               e.r   = sym[idx][31:16];
               e.i   = sym[idx][15:0];
               e.sof = (j == 0);
               e.eof = (j == NF[d] + LC[d] - 1);
               expq.push_back(e);
            end
            sym.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         din_vld[j] = 1'b0; dout_rdy[j] = 1'b0;
         din_r[j] = '0; din_i[j] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      src.delete(); sym.delete(); expq.delete(); obs.delete();
      n_acc = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if ({dout_vld[d], din_rdy[d], sof[d], eof[d], dout_r[d], dout_i[d]} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_out[%0d] got vld=%b rdy=%b sof=%b eof=%b r=%h i=%h exp all 0",
                     d, dout_vld[d], din_rdy[d], sof[d], eof[d], dout_r[d], dout_i[d]);
         end
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (din_rdy[d] !== 1'b1 || dout_vld[d] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rel[%0d] got rdy=%b vld=%b exp rdy=1 vld=0", d, din_rdy[d], dout_vld[d]);
         end
      end
   endtask

   task automatic test_single();
      bit acc;
      int b = 0;
      do_reset();
      for (int k = 0; k < 48; k++) src.push_back({16'(k), 16'(-k)});
      while (src.size() > 0 && b < 200) begin step(0, 1'b1, 1'b1, acc); b++; end
      n_vec++;
      if (dout_vld[0] !== 1'b0) begin
         n_err++;
         $display("FAIL single_lat0 got vld=%b exp 0", dout_vld[0]);
      end
      step(0, 1'b1, 1'b1, acc);
      n_vec++;
      if (dout_vld[0] !== 1'b1 || sof[0] !== 1'b1 || dout_r[0] !== 16'd32 || dout_i[0] !== 16'hFFE0) begin
         n_err++;
         $display("FAIL single_lat1 got vld=%b sof=%b r=%h i=%h exp vld=1 sof=1 r=0020 i=ffe0",
                  dout_vld[0], sof[0], dout_r[0], dout_i[0]);
      end
      while (obs.size() < 64 && b < 400) begin step(0, 1'b1, 1'b1, acc); b++; end
      n_vec++;
      if (obs.size() !== 64) begin
         n_err++;
         $display("FAIL single_count got %0d exp 64", obs.size());
      end else begin
         n_vec++;
         if (obs[16].r !== 16'd0 || !obs[16].i[15:0] === 1'b0 || obs[63].r !== 16'd47 || obs[63].eof !== 1'b1) begin
            n_err++;
            $display("FAIL single_hand got r16=%h r63=%h eof63=%b exp 0000 002f 1",
                     obs[16].r, obs[63].r, obs[63].eof);
         end
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL single_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit acc, seen, blocked;
      int b = 0, gaps = 0;
      seen = 0; blocked = 0;
      do_reset();
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 48; k++)
            src.push_back({16'(s * 256 + k), 16'(1000 - s * 256 - k)});
      while (obs.size() < 256 && b < 1000) begin
         if (seen && !dout_vld[0]) gaps++;
         if (dout_vld[0]) seen = 1;
         if (!din_rdy[0] && src.size() > 0) blocked = 1;
         step(0, 1'b1, 1'b1, acc);
         b++;
      end
      n_vec++;
      if (gaps !== 0 || blocked !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_flow got gaps=%0d blocked=%b exp gaps=0 blocked=1", gaps, blocked);
      end
      n_vec++;
      if (obs.size() !== 256 || src.size() !== 0) begin
         n_err++;
         $display("FAIL b2b_count got out=%0d left=%0d exp out=256 left=0", obs.size(), src.size());
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL b2b_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit acc, ven, rdy, stalled;
      smp_t held;
      int b = 0, unstable = 0;
      do_reset();
      for (int n = 0; n < 480; n++) src.push_back($urandom());
      while (obs.size() < 640 && b < 6000) begin
         ven = ($urandom_range(0, 9) < 7);
         rdy = $urandom_range(0, 1) == 1;
         stalled = dout_vld[0] && !rdy;
         held.r = dout_r[0]; held.i = dout_i[0]; held.sof = sof[0]; held.eof = eof[0];
         step(0, ven, rdy, acc);
         if (stalled && (dout_vld[0] !== 1'b1 || {dout_r[0], dout_i[0], sof[0], eof[0]} !== held))
            unstable++;
         b++;
      end
      n_vec++;
      if (unstable !== 0) begin
         n_err++;
         $display("FAIL bp_stable got %0d changes under stall exp 0", unstable);
      end
      n_vec++;
      if (obs.size() !== 640) begin
         n_err++;
         $display("FAIL bp_count got %0d exp 640", obs.size());
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL bp_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit acc;
      int b = 0;
      do_reset();
      for (int k = 0; k < 48; k++) src.push_back({16'(1000 + k), 16'(5000 + k)});
      while (obs.size() < 20 && b < 300) begin step(0, 1'b1, 1'b1, acc); b++; end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({dout_vld[0], din_rdy[0], sof[0], eof[0], dout_r[0], dout_i[0]} !== 36'd0) begin
         n_err++;
         $display("FAIL rstmid_out got vld=%b rdy=%b r=%h i=%h exp all 0",
                  dout_vld[0], din_rdy[0], dout_r[0], dout_i[0]);
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({dout_vld[0], din_rdy[0], sof[0], eof[0], dout_r[0], dout_i[0]} !== 36'd0) begin
         n_err++;
         $display("FAIL rstmid_hold got vld=%b rdy=%b r=%h i=%h exp all 0",
                  dout_vld[0], din_rdy[0], dout_r[0], dout_i[0]);
      end
      src.delete(); sym.delete(); expq.delete(); obs.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 48; k++) src.push_back({16'(2000 + k), 16'(3000 - k)});
      b = 0;
      while (obs.size() < 64 && b < 300) begin step(0, 1'b1, 1'b1, acc); b++; end
      repeat (20) step(0, 1'b1, 1'b1, acc);
      n_vec++;
      if (obs.size() !== 64) begin
         n_err++;
         $display("FAIL rstmid_count got %0d exp 64", obs.size());
      end else begin
         n_vec++;
         if (obs[0].r !== 16'd2032 || obs[0].sof !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_first got r=%0d sof=%b exp r=2032 sof=1", obs[0].r, obs[0].sof);
         end
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL rstmid_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
   endtask

   task automatic test_corners();
      bit acc;
      int b = 0;
      do_reset();
      for (int k = 0; k < 16; k++) src.push_back({16'(3 * k + 1), 16'(-5 * k)});
      while (obs.size() < 16 && b < 200) begin step(1, 1'b1, 1'b1, acc); b++; end
      n_vec++;
      if (obs.size() !== 16) begin
         n_err++;
         $display("FAIL lcp0_count got %0d exp 16", obs.size());
      end else begin
         n_vec++;
         if (obs[0].r !== 16'd1 || !obs[0].sof || obs[7].r !== 16'd22 || !obs[7].eof || obs[8].r !== 16'd25) begin
            n_err++;
            $display("FAIL lcp0_hand got r0=%0d r7=%0d r8=%0d sof0=%b eof7=%b exp 1 22 25 1 1",
                     obs[0].r, obs[7].r, obs[8].r, obs[0].sof, obs[7].eof);
         end
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL lcp0_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
      do_reset();
      b = 0;
      for (int k = 0; k < 32; k++) src.push_back({16'(400 + k), 16'(k)});
      while (obs.size() < 64 && b < 300) begin step(2, 1'b1, 1'b1, acc); b++; end
      n_vec++;
      if (obs.size() !== 64) begin
         n_err++;
         $display("FAIL lcpn_count got %0d exp 64", obs.size());
      end else begin
         n_vec++;
         if (obs[0].r !== 16'd400 || obs[16].r !== 16'd400 || obs[31].r !== 16'd415 || !obs[31].eof) begin
            n_err++;
            $display("FAIL lcpn_hand got r0=%0d r16=%0d r31=%0d eof31=%b exp 400 400 415 1",
                     obs[0].r, obs[16].r, obs[31].r, obs[31].eof);
         end
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL lcpn_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
   endtask

   task automatic test_both_full();
      bit acc, early;
      int b = 0;
      early = 0;
      do_reset();
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < 48; k++)
            src.push_back({16'(s * 100 + k), 16'(7 * k + s)});
      repeat (200) step(0, 1'b1, 1'b0, acc);
      n_vec++;
      if (n_acc !== 96 || din_rdy[0] !== 1'b0 || src.size() !== 48) begin
         n_err++;
         $display("FAIL full_block got acc=%0d rdy=%b left=%0d exp acc=96 rdy=0 left=48",
                  n_acc, din_rdy[0], src.size());
      end
      n_vec++;
      if (dout_vld[0] !== 1'b1 || sof[0] !== 1'b1 || dout_r[0] !== 16'd32) begin
         n_err++;
         $display("FAIL full_head got vld=%b sof=%b r=%0d exp 1 1 32", dout_vld[0], sof[0], dout_r[0]);
      end
      while (obs.size() < 192 && b < 1000) begin
         step(0, 1'b1, 1'b1, acc);
         if (acc && obs.size() < 64) early = 1;
         b++;
      end
      n_vec++;
      if (early !== 1'b0 || n_acc !== 144) begin
         n_err++;
         $display("FAIL full_release got early=%b acc=%0d exp early=0 acc=144", early, n_acc);
      end
      n_vec++;
      if (obs.size() !== 192) begin
         n_err++;
         $display("FAIL full_count got %0d exp 192", obs.size());
      end
      for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
         n_vec++;
         if (obs[j] !== expq[j]) begin
            n_err++;
            $display("FAIL full_smp[%0d] got %h exp %h", j, obs[j], expq[j]);
         end
      end
   endtask

   initial begin
      for (int j = 0; j < 3; j++) begin
         din_vld[j] = 1'b0; dout_rdy[j] = 1'b0;
         din_r[j] = '0; din_i[j] = '0;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_corners();
      test_both_full();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
